nwr_traffic_gen: RTL and testbench
==================================

Name: nwr_traffic_gen

Overview:
Parametrised, synthesizable NWRITE traffic generator that drives the user-side stream of the doorbell/NWRITE initiator (db_req). It replaces the fixed single-packet user_logic stimulus with a programmable burst engine: configurable packet count, byte length, base address and stride, and a counter or LFSR payload pattern. It sits between the control/register layer and the initiator's user_t* interface.

Parameters:
DATA_WIDTH, 64, stream data width in bits; multiple of 8; DATA_WIDTH/8 = KEEP_W
ADDR_WIDTH, 34, user_addr_o width
CNT_WIDTH, 16, width of packet count and packet index
GAP_CYCLES, 4, idle cycles inserted between consecutive packets; 0 allowed
MAX_BYTES, 256, largest legal packet byte length

Ports:
log_clk  in  1  clock
log_rst  in  1  reset, asynchronous, active-high
start_in  in  1  single-cycle pulse; latches cfg_* and begins a burst
abort_in  in  1  stop after the current packet completes
cfg_base_addr_in  in  ADDR_WIDTH  address of first packet
cfg_stride_in  in  ADDR_WIDTH  address increment per packet
cfg_pkt_bytes_in  in  12  payload bytes per packet
cfg_num_pkts_in  in  CNT_WIDTH  packets per burst; 0 = no packets
cfg_pattern_in  in  1  0 = counter, 1 = LFSR
cfg_seed_in  in  32  LFSR seed; 0 is replaced by 32'h1
nwr_ready_in  in  1  initiator can accept a new NWRITE
nwr_busy_in  in  1  initiator is transmitting
user_tready_in  in  1  stream ready
user_addr_o  out  ADDR_WIDTH  packet address, stable for the whole packet
user_tsize_o  out  12  packet byte length, stable for the whole packet
user_tdata_o  out  DATA_WIDTH  payload
user_tvalid_o  out  1  payload valid
user_tkeep_o  out  KEEP_W  byte enables
user_tlast_o  out  1  last beat of packet
busy_o  out  1  burst in progress
done_o  out  1  one-cycle pulse at burst end
aborted_o  out  1  held with done_o when the burst ended through abort; cleared on next start
cfg_err_o  out  1  one-cycle pulse; start rejected for illegal length
pkt_cnt_o  out  CNT_WIDTH  packets completed in the current burst

Behaviour:
- Reset: all outputs 0; FSM in IDLE; LFSR = 32'h1.
- Legal length: 1..KEEP_W bytes, or a multiple of KEEP_W up to MAX_BYTES. On start_in with an illegal length: cfg_err_o pulses the next cycle and the FSM stays IDLE. start_in is ignored while busy_o=1.
- FSM states: IDLE -> WAIT_RDY on a legal start. If num_pkts=0, go instead IDLE -> DONE (done_o the next cycle, pkt_cnt_o=0).
- WAIT_RDY: advance to SEND when nwr_ready_in=1 and nwr_busy_in=0 in the same cycle.
- SEND to GAP after the tlast handshake. GAP holds GAP_CYCLES cycles, then goes to WAIT_RDY, or to DONE if the last packet has been sent or abort is pending.
- DONE: asserts done_o for one cycle and drops busy_o, then returns to IDLE.
- busy_o=1 in every state except IDLE.
- user_addr_o and user_tsize_o are loaded on entry to WAIT_RDY. Packet k uses address base + k*stride, modulo 2^ADDR_WIDTH (wrap silently).
- Beats per packet = ceil(bytes/KEEP_W). Beat index b counts from 0.
- user_tvalid_o rises the first cycle in SEND. Once asserted, user_tvalid_o and user_tdata_o, user_tkeep_o and user_tlast_o hold until user_tready_in=1 (AXI-stream rule; no bubbles required within a packet).
- tkeep: all ones, except a short packet (bytes < KEEP_W), where it is MSB-aligned: ones in the top "bytes" lanes.
- Counter pattern: data = {pkt_idx zero-extended to 32 bits, b[31:0]}, replicated/truncated to DATA_WIDTH.
- LFSR pattern: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. It steps once per accepted beat, data = current LFSR value replicated. The LFSR is seeded at start and continues across packets.
- pkt_cnt_o increments on each tlast handshake; cleared at start.
- abort_in: if it is seen in any state while busy, a sticky flag is set. The current packet always completes, because the stream cannot be truncated. If abort occurs in WAIT_RDY, go directly to DONE. aborted_o=1 with done_o.
- Simultaneous last-packet completion and abort: aborted_o=0, since the burst completed normally.
- Reset mid-packet: outputs drop to 0 immediately (asynchronous); no completion is attempted.

Decomposition:
- Shared package srio_user_pkg: FSM state enum (IDLE, WAIT_RDY, SEND, GAP, DONE); pattern enum; LFSR polynomial constant 32'h80200003; function for legal-length check.
- One natural sub-module: nwr_payload_gen (pattern/LFSR data and tkeep generation, advanced by a beat-accept strobe).

Test Plan:
- Single packet: base=0x100, bytes=32, num=1, counter pattern, tready tied high -> 4 beats. Data = 0x0000_0000_0000_0000 .. 0x0000_0000_0000_0003, tkeep=8'hFF, tlast on beat 3, done_o 1+GAP cycles later, pkt_cnt_o=1.
- Burst of 3: base=0x3_FFFF_FFF0, stride=0x10, bytes=8 -> user_addr_o = 0x3_FFFF_FFF0, then 0x0 (wrap), then 0x10. Exactly GAP_CYCLES idle cycles between packets.
- Short packet: bytes=3 -> one beat, tkeep=8'hE0, tlast=1, user_tsize_o=3. Illegal bytes=12 -> cfg_err_o pulse, busy_o remains 0.
- Backpressure: random tready with LFSR pattern and seed 0 -> data frozen while stalled. Beat sequence matches a reference LFSR started at 32'h1.
- Flow control and abort: nwr_busy_in held high for 20 cycles -> tvalid stays 0. With num=5, abort_in pulsed mid packet 2 -> packet 2 completes, done_o with aborted_o=1, pkt_cnt_o=2.
- Reset asserted mid-beat -> all outputs 0 asynchronously. The next start runs a clean burst.

Source files
------------

// File: rtl/srio_user_pkg.sv
// Shared types and helpers for the SRIO user-side NWRITE traffic generator.
package srio_user_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SEND,
        GAP,
        DONE
    } nwr_state_e;

    typedef enum logic {
        PAT_COUNTER = 1'b0,
        PAT_LFSR    = 1'b1
    } pattern_e;

    // Galois (right-shift) taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY  = 32'h80200003;
    localparam logic [31:0] LFSR_RESET = 32'h00000001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic len_legal(input logic [11:0] len,
                                       input int unsigned keep_w,
                                       input int unsigned max_bytes);
        int unsigned n;
        n = 32'(len);
        return (n != 0) && ((n <= keep_w) || (((n % keep_w) == 0) && (n <= max_bytes)));
    endfunction

endpackage

// File: rtl/nwr_traffic_gen_payload.sv
// Payload data and byte-enable generation; LFSR advances once per accepted beat.
module nwr_payload_gen
    import srio_user_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    log_clk,
    input  logic                    log_rst,
    input  logic                    seed_load,
    input  logic [31:0]             seed,
    input  pattern_e                pattern,
    input  logic                    beat_accept,
    input  logic                    valid,
    input  logic [CNT_WIDTH-1:0]    pkt_idx,
    input  logic [11:0]             beat_idx,
    input  logic [11:0]             tsize,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic [DATA_WIDTH/8-1:0] tkeep
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned REP64  = (DATA_WIDTH + 63) / 64;
    localparam int unsigned REP32  = (DATA_WIDTH + 31) / 32;

    logic [31:0]         lfsr;
    logic [REP64*64-1:0] cnt_rep;
    logic [REP32*32-1:0] lfsr_rep;
    logic [KEEP_W-1:0]   all_lanes;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            lfsr <= LFSR_RESET;
        end else if (seed_load) begin
            lfsr <= (seed == '0) ? LFSR_RESET : seed;
        end else if (beat_accept) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    always_comb begin
        all_lanes = '1;
        cnt_rep   = {REP64{32'(pkt_idx), 32'(beat_idx)}};
        lfsr_rep  = {REP32{lfsr}};
        tdata     = '0;
        tkeep     = '0;
        if (valid) begin
            tdata = (pattern == PAT_LFSR) ? lfsr_rep[DATA_WIDTH-1:0] : cnt_rep[DATA_WIDTH-1:0];
            // Short packets occupy the top lanes; full-width sizes shift everything out.
            tkeep = ~(all_lanes >> tsize);
        end
    end

endmodule

// File: rtl/nwr_traffic_gen.sv
// Programmable NWRITE burst engine driving the initiator's user_t* stream.
module nwr_traffic_gen
    import srio_user_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_BYTES  = 256
) (
    input  logic                    log_clk,
    input  logic                    log_rst,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr_in,
    input  logic [ADDR_WIDTH-1:0]   cfg_stride_in,
    input  logic [11:0]             cfg_pkt_bytes_in,
    input  logic [CNT_WIDTH-1:0]    cfg_num_pkts_in,
    input  logic                    cfg_pattern_in,
    input  logic [31:0]             cfg_seed_in,
    input  logic                    nwr_ready_in,
    input  logic                    nwr_busy_in,
    input  logic                    user_tready_in,
    output logic [ADDR_WIDTH-1:0]   user_addr_o,
    output logic [11:0]             user_tsize_o,
    output logic [DATA_WIDTH-1:0]   user_tdata_o,
    output logic                    user_tvalid_o,
    output logic [DATA_WIDTH/8-1:0] user_tkeep_o,
    output logic                    user_tlast_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic                    cfg_err_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    nwr_state_e            state, nstate;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  num_q;
    pattern_e              pattern_q;
    logic [11:0]           beat_q;
    logic [11:0]           beats_m1;
    logic [GAP_W-1:0]      gap_q;
    logic                  abort_q;
    logic                  len_ok, start_ok, start_bad;
    logic                  hs, last_beat, pkt_hs, abort_pend;
    logic                  last_sent, gap_end, leave_pkt, set_aborted;

    always_comb begin
        user_tvalid_o = (state == SEND);
        busy_o        = (state != IDLE);
        done_o        = (state == DONE);
        beats_m1      = (user_tsize_o - 12'd1) / 12'(KEEP_W);
        last_beat     = (beat_q == beats_m1);
        user_tlast_o  = user_tvalid_o && last_beat;
    end

    always_comb begin
        len_ok     = len_legal(cfg_pkt_bytes_in, KEEP_W, MAX_BYTES);
        start_ok   = (state == IDLE) && start_in && len_ok;
        start_bad  = (state == IDLE) && start_in && !len_ok;
        hs         = user_tvalid_o && user_tready_in;
        pkt_hs     = hs && last_beat;
        abort_pend = abort_q || abort_in;
        // With GAP_CYCLES == 0 the packet is retired straight from SEND, before pkt_cnt_o updates.
        last_sent  = (state == SEND) ? ((pkt_cnt_o + CNT_WIDTH'(1)) == num_q) : (pkt_cnt_o == num_q);
        gap_end    = (GAP_CYCLES == 0) || (gap_q == GAP_W'(GAP_CYCLES - 1));
        leave_pkt  = (GAP_CYCLES == 0) ? ((state == SEND) && pkt_hs) : ((state == GAP) && gap_end);

        nstate      = state;
        set_aborted = 1'b0;
        unique case (state)
            IDLE:     if (start_ok) nstate = (cfg_num_pkts_in == '0) ? DONE : WAIT_RDY;
            WAIT_RDY: begin
                if (abort_pend) begin
                    nstate      = DONE;
                    set_aborted = 1'b1;
                end else if (nwr_ready_in && !nwr_busy_in) begin
                    nstate = SEND;
                end
            end
            SEND:     if (pkt_hs) nstate = GAP;
            GAP:      nstate = GAP;
            DONE:     nstate = IDLE;
            default:  nstate = IDLE;
        endcase

        if (leave_pkt) begin
            if (last_sent) begin
                nstate = DONE;
            end else if (abort_pend) begin
                nstate      = DONE;
                set_aborted = 1'b1;
            end else begin
                nstate = WAIT_RDY;
            end
        end
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state        <= IDLE;
            user_addr_o  <= '0;
            user_tsize_o <= '0;
            stride_q     <= '0;
            num_q        <= '0;
            pattern_q    <= PAT_COUNTER;
            beat_q       <= '0;
            gap_q        <= '0;
            abort_q      <= 1'b0;
            aborted_o    <= 1'b0;
            cfg_err_o    <= 1'b0;
            pkt_cnt_o    <= '0;
        end else begin
            state     <= nstate;
            cfg_err_o <= start_bad;
            if (start_ok) begin
                user_addr_o  <= cfg_base_addr_in;
                user_tsize_o <= cfg_pkt_bytes_in;
                stride_q     <= cfg_stride_in;
                num_q        <= cfg_num_pkts_in;
                pattern_q    <= pattern_e'(cfg_pattern_in);
                beat_q       <= '0;
                gap_q        <= '0;
                abort_q      <= 1'b0;
                aborted_o    <= 1'b0;
                pkt_cnt_o    <= '0;
            end else begin
                if (busy_o && abort_in) abort_q <= 1'b1;
                if (hs) beat_q <= last_beat ? '0 : beat_q + 12'd1;
                if (pkt_hs) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
                gap_q <= (state == GAP) ? gap_q + GAP_W'(1) : '0;
                if (leave_pkt && (nstate == WAIT_RDY)) user_addr_o <= user_addr_o + stride_q;
                if (set_aborted) aborted_o <= 1'b1;
            end
        end
    end

    nwr_payload_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_payload (
        .log_clk     (log_clk),
        .log_rst     (log_rst),
        .seed_load   (start_ok),
        .seed        (cfg_seed_in),
        .pattern     (pattern_q),
        .beat_accept (hs),
        .valid       (user_tvalid_o),
        .pkt_idx     (pkt_cnt_o),
        .beat_idx    (beat_q),
        .tsize       (user_tsize_o),
        .tdata       (user_tdata_o),
        .tkeep       (user_tkeep_o)
    );

endmodule

// File: tb/tb_nwr_traffic_gen.sv
// Scoreboard bench for nwr_traffic_gen: stimulus pushes expected beats, a monitor pops and compares.
module tb_nwr_traffic_gen;

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 34;
    localparam int unsigned CW   = 16;
    localparam int unsigned GAP  = 4;
    localparam int unsigned MAXB = 256;
    localparam int unsigned KW   = DW / 8;

    logic          log_clk = 1'b0;
    logic          log_rst = 1'b1;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic [AW-1:0] cfg_base_addr_in = '0;
    logic [AW-1:0] cfg_stride_in = '0;
    logic [11:0]   cfg_pkt_bytes_in = '0;
    logic [CW-1:0] cfg_num_pkts_in = '0;
    logic          cfg_pattern_in = 1'b0;
    logic [31:0]   cfg_seed_in = '0;
    logic          nwr_ready_in = 1'b1;
    logic          nwr_busy_in = 1'b0;
    logic          user_tready_in = 1'b1;
    logic [AW-1:0] user_addr_o;
    logic [11:0]   user_tsize_o;
    logic [DW-1:0] user_tdata_o;
    logic          user_tvalid_o;
    logic [KW-1:0] user_tkeep_o;
    logic          user_tlast_o;
    logic          busy_o, done_o, aborted_o, cfg_err_o;
    logic [CW-1:0] pkt_cnt_o;

    nwr_traffic_gen #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .GAP_CYCLES (GAP),
        .MAX_BYTES  (MAXB)
    ) dut (
        .log_clk          (log_clk),
        .log_rst          (log_rst),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .cfg_base_addr_in (cfg_base_addr_in),
        .cfg_stride_in    (cfg_stride_in),
        .cfg_pkt_bytes_in (cfg_pkt_bytes_in),
        .cfg_num_pkts_in  (cfg_num_pkts_in),
        .cfg_pattern_in   (cfg_pattern_in),
        .cfg_seed_in      (cfg_seed_in),
        .nwr_ready_in     (nwr_ready_in),
        .nwr_busy_in      (nwr_busy_in),
        .user_tready_in   (user_tready_in),
        .user_addr_o      (user_addr_o),
        .user_tsize_o     (user_tsize_o),
        .user_tdata_o     (user_tdata_o),
        .user_tvalid_o    (user_tvalid_o),
        .user_tkeep_o     (user_tkeep_o),
        .user_tlast_o     (user_tlast_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .aborted_o        (aborted_o),
        .cfg_err_o        (cfg_err_o),
        .pkt_cnt_o        (pkt_cnt_o)
    );

    always #5 log_clk = ~log_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [11:0]   tsize;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_cnt = 0;
    logic        exp_aborted = 1'b0;
    int unsigned done_cnt = 0;
    logic        rnd_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_lfsr_next(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    // Reference: packet k at base + k*stride, ceil(bytes/KW) beats, data by pattern rule.
    task automatic push_burst(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input logic [11:0] bytes, input int unsigned npk,
                              input logic pat, input logic [31:0] seed);
        logic [31:0] lf;
        int unsigned nb;
        beat_t       e;
        lf = (seed == 32'd0) ? 32'd1 : seed;
        nb = (32'(bytes) + KW - 1) / KW;
        for (int unsigned k = 0; k < npk; k++) begin
            for (int unsigned b = 0; b < nb; b++) begin
                e.addr  = base + AW'(k) * stride;
                e.tsize = bytes;
                e.data  = pat ? {lf, lf} : {32'(k), 32'(b)};
                e.keep  = '0;
                for (int unsigned j = 0; j < KW; j++)
                    if (32'(bytes) >= KW || j >= KW - 32'(bytes)) e.keep[j] = 1'b1;
                e.last  = (b == nb - 1);
                exp_q.push_back(e);
                if (pat) lf = ref_lfsr_next(lf);
            end
        end
    endtask

    // Monitor: pops expected beats on each handshake; checks stall hold, gaps and burst end.
    int unsigned   cyc = 0;
    int unsigned   last_tl_cyc = 0;
    logic          after_tlast = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] held_data;
    logic [KW-1:0] held_keep;
    logic          held_last;

    always @(negedge log_clk) begin : monitor
        beat_t e;
        cyc++;
        if (log_rst) begin
            after_tlast = 1'b0;
            prev_stall  = 1'b0;
            prev_valid  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(user_tvalid_o), 64'd1);
                check("stall_data", 64'(user_tdata_o), 64'(held_data));
                check("stall_keep_last", 64'({user_tkeep_o, user_tlast_o}), 64'({held_keep, held_last}));
            end
            if (user_tvalid_o && !prev_valid && after_tlast) begin
                // GAP_CYCLES in GAP plus one WAIT_RDY cycle with the initiator ready.
                check("pkt_gap", 64'(cyc - last_tl_cyc - 1), 64'(GAP + 1));
                after_tlast = 1'b0;
            end
            if (user_tvalid_o && user_tready_in) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_addr", 64'(user_addr_o), 64'(e.addr));
                    check("beat_tsize", 64'(user_tsize_o), 64'(e.tsize));
                    check("beat_data", 64'(user_tdata_o), 64'(e.data));
                    check("beat_keep", 64'(user_tkeep_o), 64'(e.keep));
                    check("beat_last", 64'(user_tlast_o), 64'(e.last));
                end
                if (user_tlast_o) begin
                    last_tl_cyc = cyc;
                    after_tlast = 1'b1;
                end
            end
            if (done_o) begin
                done_cnt++;
                check("done_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_cnt));
                check("done_aborted", 64'(aborted_o), 64'(exp_aborted));
                if (after_tlast) check("done_latency", 64'(cyc - last_tl_cyc), 64'(GAP + 1));
                after_tlast = 1'b0;
            end
            prev_valid = user_tvalid_o;
            prev_stall = user_tvalid_o && !user_tready_in;
            held_data  = user_tdata_o;
            held_keep  = user_tkeep_o;
            held_last  = user_tlast_o;
        end
    end

    initial begin
        forever begin
            @(posedge log_clk);
            #1;
            user_tready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge log_clk);
            #1;
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input logic [11:0] bytes, input int unsigned num,
                               input logic pat, input logic [31:0] seed);
        cfg_base_addr_in = base;
        cfg_stride_in    = stride;
        cfg_pkt_bytes_in = bytes;
        cfg_num_pkts_in  = CW'(num);
        cfg_pattern_in   = pat;
        cfg_seed_in      = seed;
        start_in         = 1'b1;
        tick(1);
        start_in         = 1'b0;
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned limit);
        int unsigned n = 0;
        while (done_cnt == d0 && n < limit) begin
            tick(1);
            n++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        tick(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [11:0] bytes, input int unsigned num,
                             input logic pat, input logic [31:0] seed);
        int unsigned d0;
        push_burst(base, stride, bytes, num, pat, seed);
        exp_cnt     = num;
        exp_aborted = 1'b0;
        d0          = done_cnt;
        start_burst(base, stride, bytes, num, pat, seed);
        wait_done(d0, 5000);
    endtask

    task automatic illegal_start(input logic [11:0] bytes);
        cfg_pkt_bytes_in = bytes;
        cfg_num_pkts_in  = CW'(1);
        start_in         = 1'b1;
        tick(1);
        start_in         = 1'b0;
        check("cfg_err_pulse", 64'(cfg_err_o), 64'd1);
        check("cfg_err_idle", 64'(busy_o), 64'd0);
        tick(1);
        check("cfg_err_single", 64'(cfg_err_o), 64'd0);
        check("cfg_err_stay_idle", 64'(busy_o), 64'd0);
    endtask

    initial begin : stimulus
        int unsigned d0;
        int unsigned n;
        int unsigned vcount;
        logic [11:0] rb;

        tick(3);
        check("reset_addr", 64'(user_addr_o), 64'd0);
        check("reset_tdata", 64'(user_tdata_o), 64'd0);
        check("reset_ctrl", 64'({user_tsize_o, user_tvalid_o, user_tkeep_o, user_tlast_o, busy_o,
                                 done_o, aborted_o, cfg_err_o, pkt_cnt_o}), 64'd0);
        log_rst = 1'b0;
        tick(2);

        // Single counter packet, then a wrapping 3-packet burst, then a short packet.
        run_burst(34'h100, 34'h40, 12'd32, 1, 1'b0, 32'd0);
        run_burst(34'h3_FFFF_FFF0, 34'h10, 12'd8, 3, 1'b0, 32'd0);
        run_burst(34'h200, 34'h0, 12'd3, 1, 1'b0, 32'd0);
        run_burst(34'h0, 34'h100, 12'd256, 1, 1'b0, 32'd0);

        illegal_start(12'd12);
        illegal_start(12'd0);
        illegal_start(12'd264);

        // Zero packets: done the cycle after start, nothing on the stream.
        exp_cnt = 0; exp_aborted = 1'b0; d0 = done_cnt;
        start_burst(34'h0, 34'h0, 12'd8, 0, 1'b0, 32'd0);
        check("zero_pkts_done", 64'(done_o), 64'd1);
        wait_done(d0, 10);

        // LFSR with seed 0 under random backpressure.
        rnd_ready = 1'b1;
        run_burst(34'h1000, 34'h80, 12'd64, 3, 1'b1, 32'd0);
        run_burst(34'h2000, 34'h8, 12'd5, 4, 1'b1, 32'hDEAD_BEEF);
        rnd_ready = 1'b0;

        // start_in while busy must not disturb the running burst.
        push_burst(34'h500, 34'h20, 12'd16, 2, 1'b0, 32'd0);
        exp_cnt = 2; exp_aborted = 1'b0; d0 = done_cnt;
        start_burst(34'h500, 34'h20, 12'd16, 2, 1'b0, 32'd0);
        tick(3);
        start_burst(34'h7777, 34'h1, 12'd8, 9, 1'b1, 32'h5);
        wait_done(d0, 500);

        // Initiator busy holds off the first beat.
        nwr_busy_in = 1'b1;
        push_burst(34'h800, 34'h0, 12'd16, 1, 1'b0, 32'd0);
        exp_cnt = 1; exp_aborted = 1'b0; d0 = done_cnt;
        start_burst(34'h800, 34'h0, 12'd16, 1, 1'b0, 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (user_tvalid_o) vcount++;
            tick(1);
        end
        check("flow_no_valid", 64'(vcount), 64'd0);
        check("flow_busy", 64'(busy_o), 64'd1);
        nwr_busy_in = 1'b0;
        wait_done(d0, 500);

        // Abort during the second of five packets.
        push_burst(34'h900, 34'h40, 12'd32, 2, 1'b0, 32'd0);
        exp_cnt = 2; exp_aborted = 1'b1; d0 = done_cnt;
        start_burst(34'h900, 34'h40, 12'd32, 5, 1'b0, 32'd0);
        n = 0;
        while (!(user_tvalid_o && pkt_cnt_o == CW'(1)) && n < 300) begin
            tick(1);
            n++;
        end
        abort_in = 1'b1;
        tick(1);
        abort_in = 1'b0;
        wait_done(d0, 500);

        // Abort while waiting for the initiator: no packet sent.
        nwr_ready_in = 1'b0;
        exp_cnt = 0; exp_aborted = 1'b1; d0 = done_cnt;
        start_burst(34'hA00, 34'h40, 12'd8, 3, 1'b0, 32'd0);
        tick(3);
        abort_in = 1'b1;
        tick(1);
        abort_in = 1'b0;
        wait_done(d0, 50);
        nwr_ready_in = 1'b1;

        // Abort coincident with the last beat of the last packet: completes normally.
        push_burst(34'hB00, 34'h0, 12'd32, 1, 1'b0, 32'd0);
        exp_cnt = 1; exp_aborted = 1'b0; d0 = done_cnt;
        start_burst(34'hB00, 34'h0, 12'd32, 1, 1'b0, 32'd0);
        n = 0;
        while (!(user_tvalid_o && user_tlast_o) && n < 300) begin
            tick(1);
            n++;
        end
        abort_in = 1'b1;
        tick(1);
        abort_in = 1'b0;
        wait_done(d0, 500);

        // Asynchronous reset mid-beat, then a clean burst.
        start_burst(34'hC00, 34'h40, 12'd64, 2, 1'b1, 32'h1234);
        n = 0;
        while (!user_tvalid_o && n < 100) begin
            tick(1);
            n++;
        end
        #2;
        log_rst = 1'b1;
        #1;
        check("async_rst_stream", 64'({user_tvalid_o, user_tkeep_o, user_tlast_o, user_tsize_o}), 64'd0);
        check("async_rst_data", 64'(user_tdata_o), 64'd0);
        check("async_rst_ctrl", 64'({user_addr_o, busy_o, done_o, aborted_o, pkt_cnt_o}), 64'd0);
        exp_q.delete();
        tick(2);
        log_rst = 1'b0;
        tick(1);
        run_burst(34'hD00, 34'h40, 12'd24, 2, 1'b1, 32'd0);

        // Randomised legal bursts.
        rnd_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 0) rb = 12'($urandom_range(1, KW));
            else rb = 12'(KW * $urandom_range(1, MAXB / KW));
            run_burst(AW'({$urandom, $urandom}), AW'({$urandom, $urandom}), rb,
                      $urandom_range(1, 3), 1'($urandom_range(0, 1)), $urandom);
        end
        rnd_ready = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
